// File: rtl/uart_rx_deframer.sv
// 16x-oversampled UART receiver (8N1) with majority-voted bit sampling and framing-error detection.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit (8E1).
module uart_rx_deframer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       new_rx_data_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic       parity_err_o
);

  localparam int DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_VOTE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tick_idx;
  logic          samp0;
  logic          samp1;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          tick;
  logic          vote;
  logic          vote_now;
  logic          end_now;
  logic          start_det;

  assign tick      = (div_cnt == DIV_LAST);
  assign vote_now  = tick && (tick_idx == TICK_VOTE);
  assign end_now   = tick && (tick_idx == TICK_END);
  assign start_det = (state == IDLE) && !rxs;
  // Third sample is the live synchronised line on the voting tick itself.
  assign vote      = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  // Restarting the tick phase on the start edge centres the samples in each bit.
  always_ff @(posedge clk) begin
    if (!rstn || start_det) begin
      div_cnt  <= '0;
      tick_idx <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_idx <= (tick_idx == TICK_END) ? '0 : tick_idx + TW'(1);
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      samp0 <= 1'b0;
      samp1 <= 1'b0;
    end else if (tick) begin
      if (tick_idx == TICK_S0) samp0 <= rxs;
      if (tick_idx == TICK_S1) samp1 <= rxs;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      busy_o        <= 1'b0;
      rx_data_o     <= 8'h00;
      new_rx_data_o <= 1'b0;
      frame_err_o   <= 1'b0;
      shift         <= 8'h00;
      bit_idx       <= 3'd0;
`ifdef UART_RX_PARITY_EN
      parity_bad    <= 1'b0;
      parity_err_o  <= 1'b0;
`endif
    end else begin
      new_rx_data_o <= 1'b0;
      frame_err_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rxs) begin
            state  <= START;
            busy_o <= 1'b1;
          end
        end
        START: begin
          if (vote_now && vote) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (end_now) begin
            state   <= DATA;
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (vote_now) shift <= {vote, shift[7:1]};
          if (end_now) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (vote_now) parity_bad <= vote ^ (^shift);
          if (end_now) state <= STOP;
        end
`endif
        // Deciding at mid-stop leaves half a bit to catch an immediately following start edge.
        STOP: begin
          if (vote_now) begin
            if (vote) begin
              rx_data_o     <= shift;
              new_rx_data_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_o  <= parity_bad;
`endif
              state         <= IDLE;
              busy_o        <= 1'b0;
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

endmodule
